ysyx_23060096_lsu: RTL and testbench
====================================

Name: ysyx_23060096_lsu

Overview:
Multi-cycle load/store unit between the execute stage and the register file write port. Accepts one memory op per valid/ready handshake, drives a single-outstanding memory request/response bus, and for loads returns a sign/zero-extended result on the register-file write interface (w_en/waddr/wdata) for exactly one cycle. Stores complete without a register write.

Parameters:
ADDR_WIDTH, 5, register index width (rd, rf_waddr)
DATA_WIDTH, 32, data/address width; lane logic is defined for 32 only

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
req_valid  in  1  op offered by execute stage
req_ready  out  1  LSU can accept (IDLE only)
req_wen  in  1  1=store, 0=load
req_funct3  in  3  RV32 width/sign code
req_addr  in  DATA_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data (rs2)
req_rd  in  ADDR_WIDTH  load destination register
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  DATA_WIDTH  word-aligned address (low 2 bits 0)
mem_wen  out  1  write request
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_wstrb  out  4  byte enables (0 for loads)
mem_rsp_valid  in  1  read data / write ack
mem_rdata  in  DATA_WIDTH  read word
rf_w_en  out  1  register write strobe
rf_waddr  out  ADDR_WIDTH  register index
rf_wdata  out  DATA_WIDTH  extended load data
done  out  1  one-cycle pulse when op retires
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; all registered outputs 0; req_ready=1 after reset. Reset mid-op abandons the op; memory is reset on the same rstn, so no stale response arrives.
- FSM IDLE -> REQ -> WAIT -> (WB | IDLE).
- IDLE: req_ready=1; on req_valid latch wen/funct3/addr/wdata/rd, -> REQ.
- REQ: mem_req_valid=1, outputs stable from latched fields; hold until mem_req_ready, then -> WAIT. mem_rsp_valid in REQ is a protocol error and is ignored.
- WAIT: on mem_rsp_valid: load -> capture extended data into rf_wdata, -> WB; store -> done=1 in the following cycle via IDLE transition (done registered, asserted in the first IDLE cycle).
- WB: rf_w_en=1 for exactly one cycle (forced 0 if rd==0), done=1, -> IDLE.
- Min load latency: accept edge E0; REQ cycle 1 (ready=1); WAIT cycle 2 (rsp=1); WB cycle 3; register written at the end of cycle 3. Back-to-back: next accept in cycle 4.
- funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW. Other codes are treated as word.
- Store lanes: SB wstrb=0001<<addr[1:0], wdata={4{b}}; SH wstrb=0011<<{addr[1],0}, wdata={2{h}}; SW 1111.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; sign- or zero-extend to 32.
- Misalignment without feature: low bits beyond the access size are ignored (LW at 0x..3 reads the aligned word).

Optional Feature:
Macro YSYX_23060096_LSU_MISALIGN_CHECK_EN. When defined: adds output err (1). LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no memory request and go IDLE->WB directly. In WB, err=1 with done=1 and rf_w_en=0. Undefined funct3 also sets err. When not defined: no err port, behaviour as above.

Decomposition:
- Shared package/header: funct3 constants (LB..SW), FSM state encodings (2-bit).
- One combinational sub-module ysyx_23060096_lsu_lane: (funct3, addr[1:0], wdata, rdata) -> wstrb, lane wdata, extended rdata, misaligned flag.

Test Plan:
- LW addr 0x80000004, rdata 0xDEADBEEF, memory always ready/responds next cycle, rd=5 -> mem_addr 0x80000004, rf_w_en in cycle 3, waddr 5, wdata 0xDEADBEEF.
- LB / LBU addr 0x...03, rdata 0x80112233 -> LB wdata 0xFFFFFF80; LBU wdata 0x00000080.
- SH addr 0x...02, wdata 0x0000ABCD -> wstrb 1100, mem_wdata 0xABCDABCD, rf_w_en never high, done one pulse.
- mem_req_ready held 0 for 3 cycles, then rsp delayed 2 cycles -> mem_req_valid and mem_addr stable throughout, req_ready=0, single rf write.
- Load with rd=0 -> done=1, rf_w_en=0. rstn=0 asserted in WAIT -> next cycle state IDLE, all outputs 0, no rf write.
- Macro on: LW addr 0x...02 -> no mem_req_valid, err=1 with done, rf_w_en=0. Macro off: same op reads the aligned word at 0x...00.

Source files
------------

// File: rtl/ysyx_23060096_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 width codes,
// FSM state encoding, the latched-op record and small decode helpers.
package ysyx_23060096_lsu_pkg;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned STRB_W = 4;

    // RV32 load/store funct3 codes (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    // Fields of the accepted op still needed after the request phase
    typedef struct packed {
        logic       wen;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lsu_op_t;

    // Stores have no unsigned variants; 1xx store codes fall back to word
    function automatic logic [2:0] norm_funct3(input logic wen, input logic [2:0] f3);
        if (wen && f3[2]) begin
            return F3_W;
        end
        return f3;
    endfunction

    function automatic logic funct3_legal(input logic wen, input logic [2:0] f3);
        if (wen) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/ysyx_23060096_lsu_lane.sv
// Byte-lane steering for 32-bit accesses (purely combinational).
//   funct3     : normalised width/sign code
//   addr_lo    : byte offset within the word
//   wdata      : store data (rs2)       -> lane_wdata, wstrb
//   rdata      : memory read word       -> ext_rdata (sign/zero extended)
//   misaligned : access crosses its natural alignment
module ysyx_23060096_lsu_lane
    import ysyx_23060096_lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [LANE_W-1:0] wdata,
    input  logic [LANE_W-1:0] rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [LANE_W-1:0] lane_wdata,
    output logic [LANE_W-1:0] ext_rdata,
    output logic              misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = 8'(rdata >> {addr_lo, 3'b000});
        half_v     = 16'(rdata >> {addr_lo[1], 4'b0000});
        wstrb      = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = rdata;
        misaligned = |addr_lo;
        case (funct3)
            F3_B, F3_BU: begin
                wstrb      = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                ext_rdata  = funct3[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
                misaligned = 1'b0;
            end
            F3_H, F3_HU: begin
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                ext_rdata  = funct3[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
                misaligned = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_lsu.sv
// Multi-cycle load/store unit: execute-stage handshake in, one outstanding
// memory request, register-file write port out for loads.
// Ports: clk/rstn (sync, active-low); req_* op from execute (req_ready in
// IDLE only); mem_req_*/mem_* request bus; mem_rsp_valid/mem_rdata response;
// rf_w_en/rf_waddr/rf_wdata one-cycle load writeback; done retire pulse;
// busy while not IDLE.
// Optional: define YSYX_23060096_LSU_MISALIGN_CHECK_EN to add output err;
// misaligned or undefined-funct3 ops then skip memory and retire with err.
module ysyx_23060096_lsu
    import ysyx_23060096_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_W-1:0]     mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  done,
    output logic                  busy
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
    ,
    output logic                  err
`endif
);

    lsu_state_e            state_q, state_n;
    lsu_op_t               op_q;
    logic [ADDR_WIDTH-1:0] rd_q;

    logic [2:0]        req_f3_norm;
    logic [2:0]        lane_f3;
    logic [1:0]        lane_addr_lo;
    logic [STRB_W-1:0] lane_wstrb;
    logic [LANE_W-1:0] lane_wdata;
    logic [LANE_W-1:0] lane_rdata;
    logic              accept_bad;

    logic accept, capture, done_n, rf_w_en_n;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
    logic err_n;
    logic lane_misaligned;
`endif

    // Lane logic decodes the incoming op while IDLE, the latched op afterwards
    assign req_f3_norm  = norm_funct3(req_wen, req_funct3);
    assign lane_f3      = (state_q == ST_IDLE) ? req_f3_norm   : op_q.funct3;
    assign lane_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : op_q.addr_lo;

    ysyx_23060096_lsu_lane u_lane (
        .funct3     (lane_f3),
        .addr_lo    (lane_addr_lo),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .wstrb      (lane_wstrb),
        .lane_wdata (lane_wdata),
        .ext_rdata  (lane_rdata),
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
        .misaligned (lane_misaligned)
`else
        .misaligned ()
`endif
    );

`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
    assign accept_bad = lane_misaligned || !funct3_legal(req_wen, req_funct3);
`else
    assign accept_bad = 1'b0;
`endif

    // Next state and next values of the registered strobes
    always_comb begin
        state_n   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        done_n    = 1'b0;
        rf_w_en_n = 1'b0;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
        err_n     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = accept_bad ? ST_WB : ST_REQ;
                    done_n  = accept_bad;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
                    err_n   = accept_bad;
`endif
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done lands in WB for loads, in the following IDLE cycle for stores
                if (mem_rsp_valid) begin
                    done_n = 1'b1;
                    if (op_q.wen) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_WB;
                        capture   = 1'b1;
                        rf_w_en_n = (rd_q != '0);
                    end
                end
            end
            ST_WB: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            rf_w_en       <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            done          <= 1'b0;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
            err           <= 1'b0;
`endif
        end else begin
            state_q       <= state_n;
            req_ready     <= (state_n == ST_IDLE);
            busy          <= (state_n != ST_IDLE);
            mem_req_valid <= (state_n == ST_REQ);
            done          <= done_n;
            rf_w_en       <= rf_w_en_n;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
            err           <= err_n;
`endif
            if (accept) begin
                op_q      <= '{wen: req_wen, funct3: req_f3_norm, addr_lo: req_addr[1:0]};
                rd_q      <= req_rd;
                mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                mem_wen   <= req_wen;
                mem_wdata <= lane_wdata;
                mem_wstrb <= req_wen ? lane_wstrb : '0;
            end
            if (capture) begin
                rf_waddr <= rd_q;
                rf_wdata <= lane_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_23060096_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rf_w_en, done, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    ysyx_23060096_lsu dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    // Observations of one op collected by run_op
    logic        obs_ready0, obs_busy0, obs_ready_busy, obs_ready_after;
    logic        obs_stable, obs_timeout, obs_extra_wr, obs_extra_done;
    logic        obs_wen;
    logic [31:0] obs_addr, obs_mwdata, obs_wdata;
    logic [3:0]  obs_strb;
    logic [4:0]  obs_waddr;
    int          obs_req_cycles, obs_wr_cnt, obs_wr_cycle, obs_done_cnt, obs_done_cycle;

    // Reference: loaded value from the architectural RV32 rules
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned sh;
        logic [31:0] b, h;
        sh = addr % 4;
        b  = (rd >> (8 * sh)) & 32'hFF;
        h  = (rd >> (16 * (sh / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sh;
        sh = addr % 4;
        case (f3)
            3'b000:  return 4'(1 << sh);
            3'b001:  return 4'(3 << (2 * (sh / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_swdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return (wd & 32'hFF) * 32'h01010101;
            3'b001:  return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // Offers one op at the current falling edge and plays the memory side.
    // Memory raises ready after rdy_dly valid cycles, answers rsp_dly cycles into WAIT.
    task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                          input int rdy_dly, input int rsp_dly);
        int   phase, wait_cnt, cyc;
        logic seen;
        obs_ready0 = req_ready; obs_busy0 = busy;
        obs_ready_busy = 1'b0; obs_stable = 1'b1; obs_timeout = 1'b1;
        obs_req_cycles = 0; obs_wr_cnt = 0; obs_wr_cycle = -1; obs_done_cnt = 0; obs_done_cycle = -1;
        obs_addr = '0; obs_mwdata = '0; obs_strb = '0; obs_wen = 1'b0; obs_waddr = '0; obs_wdata = '0;
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
        phase = 0; wait_cnt = 0; seen = 1'b0; cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
            if (rf_w_en) begin obs_wr_cnt++; obs_waddr = rf_waddr; obs_wdata = rf_wdata; obs_wr_cycle = cyc; end
            if (rf_w_en === 1'b0 && cyc > 0 && phase == 2 && !wen) begin obs_wdata = obs_wdata; end
            if (!done && req_ready) obs_ready_busy = 1'b1;
            if (mem_req_valid) begin
                if (!seen) begin
                    seen = 1'b1; obs_addr = mem_addr; obs_wen = mem_wen; obs_mwdata = mem_wdata; obs_strb = mem_wstrb;
                end else if (mem_addr !== obs_addr || mem_wen !== obs_wen ||
                             mem_wdata !== obs_mwdata || mem_wstrb !== obs_strb) begin
                    obs_stable = 1'b0;
                end
                obs_req_cycles++;
            end
            if (done) begin
                obs_done_cnt++; obs_done_cycle = cyc; obs_timeout = 1'b0;
                break;
            end
            mem_rsp_valid = 1'b0; mem_rdata = $urandom; mem_req_ready = 1'b0;
            if (phase == 0 && mem_req_valid) begin
                mem_req_ready = (obs_req_cycles > rdy_dly);
                if (mem_req_ready) begin phase = 1; wait_cnt = 0; end
            end else if (phase == 1) begin
                if (wait_cnt == rsp_dly) begin
                    mem_rsp_valid = 1'b1; mem_rdata = rdata; phase = 2;
                end else begin
                    wait_cnt++;
                end
            end
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(negedge clk);
        obs_extra_wr = rf_w_en; obs_extra_done = done; obs_ready_after = req_ready;
    endtask

    task automatic test_reset();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if ({mem_req_valid, rf_w_en, done} !== 3'b000) begin fails++;
            $display("FAIL reset_strobes got=%b exp=000", {mem_req_valid, rf_w_en, done}); end
        tests++; if ({mem_addr, mem_wstrb, rf_wdata} !== 68'd0) begin fails++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_wstrb, rf_wdata); end
    endtask

    task automatic test_lw_basic();
        run_op(1'b0, 3'b010, 32'h80000004, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
        tests++; if (obs_ready0 !== 1'b1 || obs_busy0 !== 1'b0) begin fails++;
            $display("FAIL lw_idle got=%b%b exp=10", obs_ready0, obs_busy0); end
        tests++; if (obs_addr !== 32'h80000004) begin fails++; $display("FAIL lw_addr got=%h exp=80000004", obs_addr); end
        tests++; if (obs_wen !== 1'b0 || obs_strb !== 4'h0) begin fails++;
            $display("FAIL lw_wen_strb got=%b/%h exp=0/0", obs_wen, obs_strb); end
        tests++; if (obs_wr_cnt !== 1 || obs_wr_cycle !== 3) begin fails++;
            $display("FAIL lw_wr_timing got=cnt%0d cyc%0d exp=cnt1 cyc3", obs_wr_cnt, obs_wr_cycle); end
        tests++; if (obs_waddr !== 5'd5 || obs_wdata !== 32'hDEADBEEF) begin fails++;
            $display("FAIL lw_wb got=%0d/%h exp=5/deadbeef", obs_waddr, obs_wdata); end
        tests++; if (obs_done_cycle !== 3 || obs_extra_done !== 1'b0 || obs_extra_wr !== 1'b0) begin fails++;
            $display("FAIL lw_done got=cyc%0d extra%b%b exp=cyc3 extra00", obs_done_cycle, obs_extra_done, obs_extra_wr); end
        tests++; if (obs_ready_busy !== 1'b0 || obs_ready_after !== 1'b1) begin fails++;
            $display("FAIL lw_ready got=busy%b after%b exp=busy0 after1", obs_ready_busy, obs_ready_after); end
    endtask

    task automatic test_lb_lbu();
        run_op(1'b0, 3'b000, 32'h80000013, 32'h0, 5'd7, 32'h80112233, 0, 0);
        tests++; if (obs_wdata !== 32'hFFFFFF80 || obs_addr !== 32'h80000010) begin fails++;
            $display("FAIL lb got=%h@%h exp=ffffff80@80000010", obs_wdata, obs_addr); end
        run_op(1'b0, 3'b100, 32'h80000013, 32'h0, 5'd7, 32'h80112233, 0, 0);
        tests++; if (obs_wdata !== 32'h00000080) begin fails++; $display("FAIL lbu got=%h exp=00000080", obs_wdata); end
        run_op(1'b0, 3'b001, 32'h80000002, 32'h0, 5'd9, 32'h80112233, 0, 0);
        tests++; if (obs_wdata !== 32'hFFFF8011) begin fails++; $display("FAIL lh got=%h exp=ffff8011", obs_wdata); end
    endtask

    task automatic test_sh();
        run_op(1'b1, 3'b001, 32'h80000102, 32'h0000ABCD, 5'd3, 32'h0, 0, 0);
        tests++; if (obs_strb !== 4'b1100 || obs_wen !== 1'b1) begin fails++;
            $display("FAIL sh_strb got=%b/%b exp=1100/1", obs_strb, obs_wen); end
        tests++; if (obs_mwdata !== 32'hABCDABCD || obs_addr !== 32'h80000100) begin fails++;
            $display("FAIL sh_data got=%h@%h exp=abcdabcd@80000100", obs_mwdata, obs_addr); end
        tests++; if (obs_wr_cnt !== 0 || obs_extra_wr !== 1'b0) begin fails++;
            $display("FAIL sh_no_write got=%0d exp=0", obs_wr_cnt); end
        tests++; if (obs_done_cnt !== 1 || obs_done_cycle !== 3 || obs_extra_done !== 1'b0) begin fails++;
            $display("FAIL sh_done got=cyc%0d extra%b exp=cyc3 extra0", obs_done_cycle, obs_extra_done); end
    endtask

    task automatic test_stall();
        run_op(1'b0, 3'b010, 32'h80000020, 32'h0, 5'd11, 32'h12345678, 3, 2);
        tests++; if (obs_stable !== 1'b1 || obs_req_cycles !== 4) begin fails++;
            $display("FAIL stall_req got=stable%b cycles%0d exp=stable1 cycles4", obs_stable, obs_req_cycles); end
        tests++; if (obs_ready_busy !== 1'b0) begin fails++; $display("FAIL stall_ready got=1 exp=0"); end
        tests++; if (obs_wr_cnt !== 1 || obs_wr_cycle !== 8 || obs_wdata !== 32'h12345678) begin fails++;
            $display("FAIL stall_wb got=cnt%0d cyc%0d %h exp=cnt1 cyc8 12345678", obs_wr_cnt, obs_wr_cycle, obs_wdata); end
    endtask

    task automatic test_rd_zero();
        run_op(1'b0, 3'b010, 32'h80000040, 32'h0, 5'd0, 32'hCAFEF00D, 0, 0);
        tests++; if (obs_wr_cnt !== 0 || obs_done_cnt !== 1) begin fails++;
            $display("FAIL rd0 got=wr%0d done%0d exp=wr0 done1", obs_wr_cnt, obs_done_cnt); end
    endtask

    task automatic test_misalign_off();
        run_op(1'b0, 3'b010, 32'h80000062, 32'h0, 5'd4, 32'h11223344, 0, 0);
        tests++; if (obs_addr !== 32'h80000060 || obs_req_cycles !== 1) begin fails++;
            $display("FAIL misal_addr got=%h n%0d exp=80000060 n1", obs_addr, obs_req_cycles); end
        tests++; if (obs_wdata !== 32'h11223344 || obs_wr_cnt !== 1) begin fails++;
            $display("FAIL misal_data got=%h exp=11223344", obs_wdata); end
    endtask

    task automatic test_reset_mid();
        int wr;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000080; req_rd = 5'd6;
        @(negedge clk); req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        tests++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin fails++;
            $display("FAIL rstmid_wait got=busy%b mrv%b exp=busy1 mrv0", busy, mem_req_valid); end
        rstn = 1'b0;
        @(negedge clk);
        tests++; if ({busy, mem_req_valid, rf_w_en, done, req_ready} !== 5'b00001) begin fails++;
            $display("FAIL rstmid_out got=%b exp=00001", {busy, mem_req_valid, rf_w_en, done, req_ready}); end
        tests++; if ({mem_addr, mem_wstrb, rf_wdata} !== 68'd0) begin fails++;
            $display("FAIL rstmid_data got=%h/%h/%h exp=0", mem_addr, mem_wstrb, rf_wdata); end
        rstn = 1'b1; wr = 0;
        repeat (4) begin @(negedge clk); if (rf_w_en || done) wr++; end
        tests++; if (wr !== 0) begin fails++; $display("FAIL rstmid_no_write got=%0d exp=0", wr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_word [3];
        for (int i = 0; i < 3; i++) begin
            rd_word[i] = $urandom;
            run_op(1'b0, 3'b010, 32'h80001000 + 32'(4 * i), 32'h0, 5'(i + 1), rd_word[i], 0, 0);
            tests++; if (obs_ready0 !== 1'b1 || obs_wr_cycle !== 3 || obs_wdata !== rd_word[i] || obs_ready_after !== 1'b1) begin
                fails++; $display("FAIL b2b_%0d got=rdy%b cyc%0d %h exp=rdy1 cyc3 %h", i, obs_ready0, obs_wr_cycle, obs_wdata, rd_word[i]); end
        end
    endtask

    task automatic test_random();
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic [4:0]  rd;
        int          rdy, rsp, exp_wr;
        for (int i = 0; i < 40; i++) begin
            wen = 1'(($urandom % 2)); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
            rdata = $urandom; rd = 5'($urandom); rdy = $urandom_range(0, 2); rsp = $urandom_range(0, 2);
            exp_wr = (!wen && rd != 0) ? 1 : 0;
            run_op(wen, f3, addr, wd, rd, rdata, rdy, rsp);
            tests++; if (obs_timeout !== 1'b0 || obs_done_cnt !== 1 || obs_done_cycle !== rdy + rsp + 3) begin fails++;
                $display("FAIL rnd%0d_done got=to%b cyc%0d exp=to0 cyc%0d", i, obs_timeout, obs_done_cycle, rdy + rsp + 3); end
            tests++; if (obs_addr !== (addr & 32'hFFFFFFFC) || obs_wen !== wen || obs_req_cycles !== rdy + 1 || obs_stable !== 1'b1) begin
                fails++; $display("FAIL rnd%0d_req got=%h w%b n%0d exp=%h w%b n%0d", i, obs_addr, obs_wen, obs_req_cycles,
                                  addr & 32'hFFFFFFFC, wen, rdy + 1); end
            if (wen) begin
                tests++; if (obs_strb !== model_strb(f3, addr) || obs_mwdata !== model_swdata(f3, wd)) begin fails++;
                    $display("FAIL rnd%0d_st f3=%0d got=%b/%h exp=%b/%h", i, f3, obs_strb, obs_mwdata,
                             model_strb(f3, addr), model_swdata(f3, wd)); end
            end else begin
                tests++; if (obs_strb !== 4'h0) begin fails++; $display("FAIL rnd%0d_ld_strb got=%b exp=0000", i, obs_strb); end
            end
            tests++; if (obs_wr_cnt !== exp_wr || obs_extra_wr !== 1'b0) begin fails++;
                $display("FAIL rnd%0d_wr_cnt got=%0d exp=%0d", i, obs_wr_cnt, exp_wr); end
            if (exp_wr == 1) begin
                tests++; if (obs_waddr !== rd || obs_wdata !== model_load(f3, addr, rdata)) begin fails++;
                    $display("FAIL rnd%0d_ld f3=%0d got=%0d/%h exp=%0d/%h", i, f3, obs_waddr, obs_wdata, rd,
                             model_load(f3, addr, rdata)); end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_lw_basic();
        test_lb_lbu();
        test_sh();
        test_stall();
        test_rd_zero();
        test_misalign_off();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
